// File: rtl/stream_mux_if.sv
// stream_mux_if: bundles the select, input-channel and output-stream signals of stream_mux.
//   sel       channel select (ignored in round-robin mode)
//   in_data   N channels of WIDTH bits, channel i at [i*WIDTH +: WIDTH]
//   in_valid  per-channel valid
//   in_ready  per-channel ready, at most one bit high
//   out_data  registered data of the selected channel
//   out_valid output register holds an item
//   out_ready downstream accepts the item
//   out_chan  channel index that supplied out_data
// Modports: master = producer/consumer environment, slave = the mux.
interface stream_mux_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4
);
  localparam int unsigned SEL_W = $clog2(N);

  logic [SEL_W-1:0]   sel;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SEL_W-1:0]   out_chan;

  modport master (
    output sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_chan
  );

  modport slave (
    input  sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_chan
  );
endinterface

// File: rtl/stream_mux.sv
// stream_mux: N-channel, WIDTH-bit valid/ready multiplexer with a one-item registered
// output stage. MODE=0 selects the channel with bus.sel; MODE=1 arbitrates round-robin.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   bus         stream_mux_if.slave (sel, in_data/in_valid/in_ready, out_* stream)
//   xfer_count  16-bit saturating count of output transfers; present only when the
//               macro STREAM_MUX_STATS_EN is defined
module stream_mux #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned MODE  = 0
) (
  input  logic        clk,
  input  logic        rst,
  stream_mux_if.slave bus
`ifdef STREAM_MUX_STATS_EN
  ,
  output logic [15:0] xfer_count
`endif
);
  localparam int unsigned SEL_W = $clog2(N);

  logic [SEL_W-1:0] grant;
  logic             grant_vld;
  logic             load;
  logic [N-1:0]     in_ready_c;
  logic             xfer_in;
  logic [WIDTH-1:0] sel_data;

  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] chan_q;
  logic             valid_q;

  // Output register can take a new item when empty or when its item leaves this cycle
  assign load = !valid_q || bus.out_ready;

  if (MODE == 0) begin : g_sel
    // Out-of-range select (non-power-of-2 N) grants nothing
    always_comb begin
      grant     = bus.sel;
      grant_vld = (32'(bus.sel) < N);
    end
  end else begin : g_rr
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] rr_idx;

    // First valid channel scanning upward from ptr_q+1, wrapping at N
    always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      rr_idx    = '0;
      for (int unsigned k = 1; k <= N; k++) begin
        rr_idx = SEL_W'((32'(ptr_q) + k) % N);
        if (!grant_vld && bus.in_valid[rr_idx]) begin
          grant     = rr_idx;
          grant_vld = 1'b1;
        end
      end
    end

    // Reset to N-1 so channel 0 wins first
    always_ff @(posedge clk) begin
      if (rst) begin
        ptr_q <= SEL_W'(N - 1);
      end else if (xfer_in) begin
        ptr_q <= grant;
      end
    end
  end

  // Ready only on the granted channel; data mux uses constant slices
  always_comb begin
    in_ready_c = '0;
    sel_data   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant == SEL_W'(i)) begin
        in_ready_c[i] = grant_vld && load;
        sel_data      = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer_in = |(bus.in_valid & in_ready_c);

  // Output stage: load on input transfer, otherwise drain on output transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
    end else if (xfer_in) begin
      data_q  <= sel_data;
      chan_q  <= grant;
      valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
  assign bus.out_valid = valid_q;

`ifdef STREAM_MUX_STATS_EN
  logic [15:0] xfer_cnt_q;

  // Saturating output-transfer counter
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt_q <= '0;
    end else if (valid_q && bus.out_ready && (xfer_cnt_q != 16'hFFFF)) begin
      xfer_cnt_q <= xfer_cnt_q + 16'd1;
    end
  end

  assign xfer_count = xfer_cnt_q;
`endif
endmodule

// File: tb/tb_stream_mux.sv
// tb_stream_mux: directed, self-checking bench for stream_mux.
// Instances: u_m0 (MODE=0, N=4), u_m1 (MODE=1, N=4), u_m3 (MODE=0, N=3), all WIDTH=8.
// Honours STREAM_MUX_STATS_EN for the transfer counter checks.
module tb_stream_mux;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  stream_mux_if #(.WIDTH(8), .N(4)) if0 ();
  stream_mux_if #(.WIDTH(8), .N(4)) if1 ();
  stream_mux_if #(.WIDTH(8), .N(3)) if3 ();

`ifdef STREAM_MUX_STATS_EN
  logic [15:0] cnt0, cnt1, cnt3;
`endif

  stream_mux #(.WIDTH(8), .N(4), .MODE(0)) u_m0 (
    .clk(clk), .rst(rst), .bus(if0)
`ifdef STREAM_MUX_STATS_EN
    , .xfer_count(cnt0)
`endif
  );
  stream_mux #(.WIDTH(8), .N(4), .MODE(1)) u_m1 (
    .clk(clk), .rst(rst), .bus(if1)
`ifdef STREAM_MUX_STATS_EN
    , .xfer_count(cnt1)
`endif
  );
  stream_mux #(.WIDTH(8), .N(3), .MODE(0)) u_m3 (
    .clk(clk), .rst(rst), .bus(if3)
`ifdef STREAM_MUX_STATS_EN
    , .xfer_count(cnt3)
`endif
  );

  typedef struct {
    logic [1:0] sel;
    logic [3:0] valid;
    logic       ord;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [7:0] exp_data;
    logic [1:0] exp_chan;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_seq[12];

  initial begin
    // in_data for u_m0: ch3=D3 ch2=A5 ch1=5A ch0=3C
    vecs[0] = '{2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    vecs[1] = '{2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2};
    vecs[2] = '{2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 8'h3C, 2'd0};
    vecs[3] = '{2'd3, 4'h0, 1'b1, 4'b1000, 1'b0, 8'h3C, 2'd0};
    vecs[4] = '{2'd1, 4'h2, 1'b0, 4'b0010, 1'b1, 8'h5A, 2'd1};
    vecs[5] = '{2'd1, 4'h0, 1'b1, 4'b0010, 1'b0, 8'h5A, 2'd1};
    vecs[6] = '{2'd3, 4'h8, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3};

    rst = 1'b1;
    if0.sel = 2'd2; if0.in_data = 32'hD3A55A3C; if0.in_valid = 4'hF; if0.out_ready = 1'b1;
    if1.sel = 2'd0; if1.in_data = 32'h13121110; if1.in_valid = 4'hF; if1.out_ready = 1'b1;
    if3.sel = 2'd0; if3.in_data = 24'h332211;   if3.in_valid = 3'h7; if3.out_ready = 1'b1;

    // Reset held for two cycles with everything valid
    step();
    step();
    check("rst_m0_valid", 32'(if0.out_valid), 32'd0);
    check("rst_m0_data",  32'(if0.out_data),  32'h00);
    check("rst_m0_chan",  32'(if0.out_chan),  32'd0);
    check("rst_m1_valid", 32'(if1.out_valid), 32'd0);
    check("rst_m3_valid", 32'(if3.out_valid), 32'd0);
`ifdef STREAM_MUX_STATS_EN
    check("rst_cnt0", 32'(cnt0), 32'd0);
`endif
    rst = 1'b0;
    if1.in_valid = 4'h0;
    if3.in_valid = 3'h0;

    // MODE=0 table
    for (int v = 0; v < 7; v++) begin
      if0.sel = vecs[v].sel;
      if0.in_valid = vecs[v].valid;
      if0.out_ready = vecs[v].ord;
      #1;
      check($sformatf("v%0d_in_ready", v), 32'(if0.in_ready), 32'(vecs[v].exp_rdy));
      step();
      check($sformatf("v%0d_out_valid", v), 32'(if0.out_valid), 32'(vecs[v].exp_ov));
      check($sformatf("v%0d_out_data", v),  32'(if0.out_data),  32'(vecs[v].exp_data));
      check($sformatf("v%0d_out_chan", v),  32'(if0.out_chan),  32'(vecs[v].exp_chan));
    end

    // Backpressure: D3 from ch3 held for 5 cycles, nothing ready
    if0.sel = 2'd0; if0.in_valid = 4'hF; if0.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_in_ready", 32'(if0.in_ready), 32'd0);
      step();
      check("bp_out_valid", 32'(if0.out_valid), 32'd1);
      check("bp_out_data",  32'(if0.out_data),  32'hD3);
    end
    // Release: new item replaces old on the same edge
    if0.out_ready = 1'b1;
    #1;
    check("bp_rel_in_ready", 32'(if0.in_ready), 32'b0001);
    step();
    check("bp_rel_valid", 32'(if0.out_valid), 32'd1);
    check("bp_rel_data",  32'(if0.out_data),  32'h3C);
    check("bp_rel_chan",  32'(if0.out_chan),  32'd0);

    // MODE=1 fairness: all valid, 0,1,2,3,0,1,2,3
    if1.in_valid = 4'hF;
    #1;
    check("rr_first_ready", 32'(if1.in_ready), 32'b0001);
    for (int c = 0; c < 8; c++) begin
      step();
      check("rr_fair_valid", 32'(if1.out_valid), 32'd1);
      check("rr_fair_chan",  32'(if1.out_chan),  32'(c % 4));
      check("rr_fair_data",  32'(if1.out_data),  32'h10 + 32'(c % 4));
    end
    // Sparse: ch1 and ch3 alternate, then ch1 alone
    exp_seq = '{1, 3, 1, 3, 1, 1, 1, 0, 0, 0, 0, 0};
    if1.in_valid = 4'b1010;
    for (int c = 0; c < 7; c++) begin
      if (c == 4) if1.in_valid = 4'b0010;
      step();
      check("rr_sparse_chan", 32'(if1.out_chan), 32'(exp_seq[c]));
      check("rr_sparse_data", 32'(if1.out_data), 32'h10 + 32'(exp_seq[c]));
    end

    // N=3, sel out of range: nothing granted
    if3.sel = 2'd3; if3.in_valid = 3'b111; if3.out_ready = 1'b1;
    #1;
    check("n3_oor_ready", 32'(if3.in_ready), 32'd0);
    step();
    check("n3_oor_valid", 32'(if3.out_valid), 32'd0);
`ifdef STREAM_MUX_STATS_EN
    check("n3_oor_cnt", 32'(cnt3), 32'd0);
`endif
    if3.sel = 2'd2;
    #1;
    check("n3_sel2_ready", 32'(if3.in_ready), 32'b100);
    step();
    check("n3_sel2_data", 32'(if3.out_data), 32'h33);
    check("n3_sel2_chan", 32'(if3.out_chan), 32'd2);

`ifdef STREAM_MUX_STATS_EN
    // Saturation: continuous stream on u_m0, counter preloaded near the top
    if0.sel = 2'd0; if0.in_valid = 4'b0001; if0.out_ready = 1'b1;
    step();
    force u_m0.xfer_cnt_q = 16'hFFFC;
    #1;
    release u_m0.xfer_cnt_q;
    step();
    check("cnt_fffd", 32'(cnt0), 32'hFFFD);
    step();
    check("cnt_fffe", 32'(cnt0), 32'hFFFE);
    step();
    check("cnt_ffff", 32'(cnt0), 32'hFFFF);
    step();
    check("cnt_sat", 32'(cnt0), 32'hFFFF);
    // Mid-stream reset clears counter and held item
    rst = 1'b1;
    step();
    check("cnt_rst", 32'(cnt0), 32'd0);
    check("cnt_rst_valid", 32'(if0.out_valid), 32'd0);
    rst = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
